// File: rtl/rob_wb_arb_if.sv
// rtl/rob_wb_arb_if.sv - writeback arbiter bus bundle
// Purpose: groups the execution-unit writeback handshake, the retire flush
//   and the registered ROB result port into one bundle.
// Signals:
//   wb_valid_ex   [NUM_REQ]            requester i has a result pending
//   wb_result_ex  [NUM_REQ][RESULT_W]  per-requester result payload (t_rob_result)
//   wb_ready_ex   [NUM_REQ]            one-hot grant back to the requesters
//   flush_rb1                          branch mispredict flush from retire
//   ro_valid_rb0                       registered result valid to ROB
//   ro_result_rb0 [RESULT_W]           registered result payload to ROB
// Modports: master = execution units / retire side, slave = arbiter.
interface rob_wb_arb_if #(
  parameter int NUM_REQ  = 4,
  parameter int RESULT_W = 32
);
  logic [NUM_REQ-1:0]               wb_valid_ex;
  logic [NUM_REQ-1:0][RESULT_W-1:0] wb_result_ex;
  logic [NUM_REQ-1:0]               wb_ready_ex;
  logic                             flush_rb1;
  logic                             ro_valid_rb0;
  logic [RESULT_W-1:0]              ro_result_rb0;

  modport master (
    output wb_valid_ex,
    output wb_result_ex,
    output flush_rb1,
    input  wb_ready_ex,
    input  ro_valid_rb0,
    input  ro_result_rb0
  );

  modport slave (
    input  wb_valid_ex,
    input  wb_result_ex,
    input  flush_rb1,
    output wb_ready_ex,
    output ro_valid_rb0,
    output ro_result_rb0
  );
endinterface

// File: rtl/rob_wb_arb.sv
// rtl/rob_wb_arb.sv - ROB writeback arbiter with starvation, priority and round-robin tiers
// Purpose: picks one of NUM_REQ writeback requesters per cycle and registers
//   its result onto the ROB's single result port (1-cycle latency).
//   Grant order: starved requester, then PRI_MASK requester, then round-robin.
// Ports:
//   clk    in  clock
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of rob_wb_arb_if (wb_valid_ex/wb_result_ex/wb_ready_ex,
//          flush_rb1, ro_valid_rb0/ro_result_rb0)
module rob_wb_arb #(
  parameter int                 NUM_REQ      = 4,
  parameter logic [NUM_REQ-1:0] PRI_MASK     = NUM_REQ'(1),
  parameter int                 STARVE_LIMIT = 8,
  parameter int                 RESULT_W     = 32
) (
  input logic         clk,
  input logic         reset,
  rob_wb_arb_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    wait_cnt_q [NUM_REQ];
  logic [CNT_W-1:0]    wait_cnt_d [NUM_REQ];
  logic                ro_valid_q, ro_valid_d;
  logic [RESULT_W-1:0] ro_result_q, ro_result_d;

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    win_idx;
  logic                win_found;
  logic [PTR_W-1:0]    rr_idx;

  // Winner selection. Each tier only looks when no earlier tier found a winner,
  // so the tier order alone gives the required precedence.
  always_comb begin : select_winner
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    rr_idx    = '0;
    if (!reset && !bus.flush_rb1) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && bus.wb_valid_ex[i] && (wait_cnt_q[i] == LIMIT)) begin
          win_found = 1'b1;
          win_idx   = PTR_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && bus.wb_valid_ex[i] && PRI_MASK[i]) begin
          win_found = 1'b1;
          win_idx   = PTR_W'(i);
        end
      end
      // Round-robin scan starting at rr_ptr and wrapping; PRI requesters are
      // excluded here since any valid one was already taken above.
      for (int k = 0; k < NUM_REQ; k++) begin
        rr_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!win_found && bus.wb_valid_ex[rr_idx] && !PRI_MASK[rr_idx]) begin
          win_found = 1'b1;
          win_idx   = rr_idx;
        end
      end
    end
    if (win_found) begin
      grant[win_idx] = 1'b1;
    end
  end

  always_comb begin : next_state
    rr_ptr_d    = rr_ptr_q;
    ro_valid_d  = win_found;
    ro_result_d = ro_result_q;
    if (win_found) begin
      rr_ptr_d    = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
      ro_result_d = bus.wb_result_ex[win_idx];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_cnt_d[i] = wait_cnt_q[i];
      if (bus.flush_rb1 || !bus.wb_valid_ex[i] || grant[i]) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != LIMIT) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      ro_valid_q  <= 1'b0;
      ro_result_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      ro_valid_q  <= ro_valid_d;
      ro_result_q <= ro_result_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign bus.wb_ready_ex   = grant;
  assign bus.ro_valid_rb0  = ro_valid_q;
  assign bus.ro_result_rb0 = ro_result_q;

  ap_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.wb_ready_ex));
  ap_grant_valid: assert property (@(posedge clk) disable iff (reset)
    (bus.wb_ready_ex & ~bus.wb_valid_ex) == '0);
  ap_no_flush_grant: assert property (@(posedge clk) disable iff (reset)
    bus.flush_rb1 |-> (bus.wb_ready_ex == '0));

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_chk
    ap_payload_stable: assert property (@(posedge clk) disable iff (reset)
      (bus.wb_valid_ex[g] && !bus.wb_ready_ex[g] && !bus.flush_rb1) |=> $stable(bus.wb_result_ex[g]));
    ap_cnt_bound: assert property (@(posedge clk) disable iff (reset)
      wait_cnt_q[g] <= LIMIT);
  end
endmodule

// File: tb/tb_rob_wb_arb.sv
// tb/tb_rob_wb_arb.sv - directed vector bench for rob_wb_arb
module tb_rob_wb_arb;
  localparam int         NUM_REQ      = 4;
  localparam int         STARVE_LIMIT = 4;
  localparam int         RESULT_W     = 32;
  localparam logic [3:0] PRI_MASK     = 4'b0001;

  localparam logic [31:0] R0 = 32'hA000_0000;
  localparam logic [31:0] R1 = 32'hA111_1111;
  localparam logic [31:0] R2 = 32'hA222_2222;
  localparam logic [31:0] R3 = 32'hA333_3333;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  rob_wb_arb_if #(.NUM_REQ(NUM_REQ), .RESULT_W(RESULT_W)) bus ();

  rob_wb_arb #(
    .NUM_REQ     (NUM_REQ),
    .PRI_MASK    (PRI_MASK),
    .STARVE_LIMIT(STARVE_LIMIT),
    .RESULT_W    (RESULT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic        flush;
    logic [3:0]  exp_ready;
    logic        exp_ro_valid;
    logic [31:0] exp_ro_result;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic [3:0] v, input logic f, input logic [3:0] er,
                     input logic ev, input logic [31:0] eres);
    vec_t t;
    t.valid         = v;
    t.flush         = f;
    t.exp_ready     = er;
    t.exp_ro_valid  = ev;
    t.exp_ro_result = eres;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] er,
                               input logic ev, input logic [31:0] eres);
    check({tag, " ready"},     32'(bus.wb_ready_ex),  32'(er));
    check({tag, " ro_valid"},  32'(bus.ro_valid_rb0), 32'(ev));
    check({tag, " ro_result"}, bus.ro_result_rb0,     eres);
  endtask

  initial begin
    // single requester, then round-robin 1,2,3 from rr_ptr=0
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0);
    add(4'b0100, 1'b0, 4'b0100, 1'b0, 32'h0);
    add(4'b0000, 1'b0, 4'b0000, 1'b1, R2);
    add(4'b1000, 1'b0, 4'b1000, 1'b0, R2);
    add(4'b1110, 1'b0, 4'b0010, 1'b1, R3);
    add(4'b1110, 1'b0, 4'b0100, 1'b1, R1);
    add(4'b1110, 1'b0, 4'b1000, 1'b1, R2);
    add(4'b1110, 1'b0, 4'b0010, 1'b1, R3);
    add(4'b1110, 1'b0, 4'b0100, 1'b1, R1);
    add(4'b1110, 1'b0, 4'b1000, 1'b1, R2);
    // PRI req0 against req3: req3 starves after 4 waits
    add(4'b0000, 1'b0, 4'b0000, 1'b1, R3);
    add(4'b1001, 1'b0, 4'b0001, 1'b0, R3);
    add(4'b1001, 1'b0, 4'b0001, 1'b1, R0);
    add(4'b1001, 1'b0, 4'b0001, 1'b1, R0);
    add(4'b1001, 1'b0, 4'b0001, 1'b1, R0);
    add(4'b1001, 1'b0, 4'b1000, 1'b1, R0);
    add(4'b1001, 1'b0, 4'b0001, 1'b1, R3);
    // req1 and req2 starve together: lowest index first, then req0
    add(4'b0111, 1'b0, 4'b0001, 1'b1, R0);
    add(4'b0111, 1'b0, 4'b0001, 1'b1, R0);
    add(4'b0111, 1'b0, 4'b0001, 1'b1, R0);
    add(4'b0111, 1'b0, 4'b0001, 1'b1, R0);
    add(4'b0111, 1'b0, 4'b0010, 1'b1, R0);
    add(4'b0111, 1'b0, 4'b0100, 1'b1, R1);
    add(4'b0111, 1'b0, 4'b0001, 1'b1, R2);
    // flush: no grant, prior result still shows, counters restart from 0
    add(4'b1111, 1'b1, 4'b0000, 1'b1, R0);
    add(4'b1111, 1'b0, 4'b0001, 1'b0, R0);
    add(4'b1111, 1'b0, 4'b0001, 1'b1, R0);
    add(4'b1111, 1'b0, 4'b0001, 1'b1, R0);
    add(4'b1111, 1'b0, 4'b0001, 1'b1, R0);
    add(4'b1111, 1'b0, 4'b0010, 1'b1, R0);
    add(4'b1111, 1'b0, 4'b0100, 1'b1, R1);
    add(4'b1111, 1'b0, 4'b1000, 1'b1, R2);
    add(4'b1111, 1'b0, 4'b0001, 1'b1, R3);

    bus.wb_result_ex[0] = R0;
    bus.wb_result_ex[1] = R1;
    bus.wb_result_ex[2] = R2;
    bus.wb_result_ex[3] = R3;
    bus.flush_rb1       = 1'b0;
    bus.wb_valid_ex     = 4'b1111;

    // no grant and cleared outputs while reset is held
    #12;
    check_outputs("in_reset", 4'b0000, 1'b0, 32'h0);
    @(negedge clk);
    bus.wb_valid_ex = 4'b0000;
    reset           = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.wb_valid_ex = vecs[i].valid;
      bus.flush_rb1   = vecs[i].flush;
      #1;
      check_outputs($sformatf("row%0d", i), vecs[i].exp_ready,
                    vecs[i].exp_ro_valid, vecs[i].exp_ro_result);
    end

    // reset mid-operation: move rr_ptr to 3 first so its reset is visible
    @(negedge clk);
    bus.wb_valid_ex = 4'b0100;
    bus.flush_rb1   = 1'b0;
    #1;
    check_outputs("pre_rst_a", 4'b0100, 1'b1, R0);
    @(negedge clk);
    bus.wb_valid_ex = 4'b1010;
    #1;
    check_outputs("pre_rst_b", 4'b1000, 1'b1, R2);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("rst_assert", 4'b0000, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs("post_rst_a", 4'b0010, 1'b0, 32'h0);
    @(negedge clk);
    bus.wb_valid_ex = 4'b0000;
    #1;
    check_outputs("post_rst_b", 4'b0000, 1'b1, R1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
